batch_eval_ctrl: RTL and testbench

//  Synthesisable on-chip batch evaluator for the MNIST classifier top. Reads NUM_IMAGES images

---
 rtl/batch_eval_ctrl_if.sv | 43 ++++
 rtl/batch_eval_ctrl.sv | 170 +++++++++++++++++
 tb/tb_batch_eval_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/batch_eval_ctrl_if.sv
// Bundle of every batch evaluator signal except clock and reset.
// Modport master is the controller side; slave is the ROMs/classifier/host side.
interface batch_eval_ctrl_if #(
  parameter int IMG_PIXELS = 784,
  parameter int PIXEL_W    = 1,
  parameter int NUM_IMAGES = 1000,
  parameter int LABEL_W    = 4
);
  localparam int ADDR_W = $clog2(NUM_IMAGES * IMG_PIXELS);
  localparam int IDX_W  = $clog2(NUM_IMAGES + 1);

  // Handshakes: valid_out and res_valid are one-way strobes with no ready.
  // The receiver must take data on every cycle its valid is high.
  // start is a one-cycle pulse that is honoured only when no batch is running.
  logic               start;
  logic [ADDR_W-1:0]  pix_addr;
  logic [PIXEL_W-1:0] pix_rdata;
  logic [IDX_W-1:0]   label_addr;
  logic [LABEL_W-1:0] label_rdata;
  logic [PIXEL_W-1:0] data_out;
  logic               valid_out;
  logic               res_valid;
  logic [LABEL_W-1:0] res_pred;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   img_count;
  logic [IDX_W-1:0]   hit_count;
  logic [IDX_W-1:0]   timeout_cnt;
  logic               err_spur;
  logic [2:0]         state_dbg;

  modport master (
    input  start, pix_rdata, label_rdata, res_valid, res_pred,
    output pix_addr, label_addr, data_out, valid_out, busy, done,
           img_count, hit_count, timeout_cnt, err_spur, state_dbg
  );

  modport slave (
    output start, pix_rdata, label_rdata, res_valid, res_pred,
    input  pix_addr, label_addr, data_out, valid_out, busy, done,
           img_count, hit_count, timeout_cnt, err_spur, state_dbg
  );
endinterface

// File: rtl/batch_eval_ctrl.sv
// Batch evaluator: streams images from a pixel ROM to the classifier and scores predictions against a label ROM.
// Optional per-image WAIT timeout is compiled in with the macro BATCH_TIMEOUT_EN.
module batch_eval_ctrl #(
  parameter int IMG_PIXELS     = 784,
  parameter int PIXEL_W        = 1,
  parameter int NUM_IMAGES     = 1000,
  parameter int LABEL_W        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  batch_eval_ctrl_if.master bus
);
  localparam int ADDR_W = $clog2(NUM_IMAGES * IMG_PIXELS);
  localparam int IDX_W  = $clog2(NUM_IMAGES + 1);
  localparam int PIX_W  = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;

  localparam logic [ADDR_W-1:0] PIX_STEP = ADDR_W'(IMG_PIXELS);
  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(IMG_PIXELS - 1);
  localparam logic [IDX_W-1:0]  IMG_LAST = IDX_W'(NUM_IMAGES);

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_WAIT, S_SCORE, S_DONE
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  pix_addr_q;
  logic [PIX_W-1:0]   pix_idx_q;
  logic [IDX_W-1:0]   label_addr_q;
  logic [IDX_W-1:0]   img_count_q;
  logic [IDX_W-1:0]   hit_count_q;
  logic [LABEL_W-1:0] label_q;
  logic [LABEL_W-1:0] pred_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               err_spur_q;

  logic               start_ok;
  logic               spur_hit;
  logic               hit_d;
  logic               timed_out;
  logic [IDX_W-1:0]   img_count_d;

`ifdef BATCH_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0]  wait_cnt_q;
  logic             timed_out_q;
  logic [IDX_W-1:0] timeout_cnt_q;

  assign timed_out       = timed_out_q;
  assign bus.timeout_cnt = timeout_cnt_q;
`else
  // The timeout length only matters when the timeout is built in.
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timed_out          = 1'b0;
  assign bus.timeout_cnt    = '0;
`endif

  assign start_ok    = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  assign spur_hit    = bus.res_valid && (state_q != S_WAIT);
  assign img_count_d = img_count_q + 1'b1;
  assign hit_d       = (pred_q == label_q) && !timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      pix_addr_q    <= '0;
      pix_idx_q     <= '0;
      label_addr_q  <= '0;
      img_count_q   <= '0;
      hit_count_q   <= '0;
      label_q       <= '0;
      pred_q        <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_spur_q    <= 1'b0;
`ifdef BATCH_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timed_out_q   <= 1'b0;
      timeout_cnt_q <= '0;
`endif
    end else begin
      // The ROM's own output register is the pixel data stage, so only the valid is delayed here.
      valid_q <= (state_q == S_STREAM);
      if (spur_hit) err_spur_q <= 1'b1;

      if (start_ok) begin
        state_q       <= S_STREAM;
        base_q        <= '0;
        pix_addr_q    <= '0;
        pix_idx_q     <= '0;
        label_addr_q  <= '0;
        img_count_q   <= '0;
        hit_count_q   <= '0;
        err_spur_q    <= 1'b0;
        busy_q        <= 1'b1;
        done_q        <= 1'b0;
`ifdef BATCH_TIMEOUT_EN
        timeout_cnt_q <= '0;
`endif
      end else begin
        case (state_q)
          S_STREAM: begin
            if (pix_idx_q == PIX_LAST) begin
              label_q <= bus.label_rdata;
              state_q <= S_WAIT;
`ifdef BATCH_TIMEOUT_EN
              wait_cnt_q  <= '0;
              timed_out_q <= 1'b0;
`endif
            end else begin
              pix_idx_q  <= pix_idx_q + 1'b1;
              pix_addr_q <= pix_addr_q + 1'b1;
            end
          end
          S_WAIT: begin
            if (bus.res_valid) begin
              pred_q  <= bus.res_pred;
              state_q <= S_SCORE;
            end
`ifdef BATCH_TIMEOUT_EN
            else if (wait_cnt_q == TO_LAST) begin
              timed_out_q   <= 1'b1;
              timeout_cnt_q <= timeout_cnt_q + 1'b1;
              state_q       <= S_SCORE;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
`endif
          end
          S_SCORE: begin
            img_count_q <= img_count_d;
            if (hit_d) hit_count_q <= hit_count_q + 1'b1;
            if (img_count_d == IMG_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Next image starts one full image further on; running sum instead of img_idx*IMG_PIXELS.
              state_q      <= S_STREAM;
              base_q       <= base_q + PIX_STEP;
              pix_addr_q   <= base_q + PIX_STEP;
              pix_idx_q    <= '0;
              label_addr_q <= label_addr_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.pix_addr   = pix_addr_q;
  assign bus.label_addr = label_addr_q;
  assign bus.data_out   = valid_q ? bus.pix_rdata : '0;
  assign bus.valid_out  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.img_count  = img_count_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.err_spur   = err_spur_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_batch_eval_ctrl.sv
// Directed bench for batch_eval_ctrl: 4-pixel images, 3 images, model classifier with latency 5.
// Batch scenarios come from a vector table; reset abort, start-while-busy and spurious strobes are hand sequences.
module tb_batch_eval_ctrl;
  localparam int P   = 4;
  localparam int NI  = 3;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  batch_eval_ctrl_if #(.IMG_PIXELS(P), .PIXEL_W(1), .NUM_IMAGES(NI), .LABEL_W(4)) bus ();

  batch_eval_ctrl #(
    .IMG_PIXELS(P), .PIXEL_W(1), .NUM_IMAGES(NI), .LABEL_W(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [0:0] pix_rom   [16];
  logic [3:0] label_rom [4];

  // Synchronous ROMs with one cycle of read latency
  always @(posedge clk) begin
    bus.pix_rdata   <= pix_rom[bus.pix_addr];
    bus.label_rdata <= label_rom[bus.label_addr];
  end

  typedef struct {
    logic [2:0][3:0] pred;
    int              spur_img;
    int              exp_hit;
    logic            exp_err;
  } vec_t;

  vec_t vec [5];

  int tests = 0;
  int fails = 0;

  int beat, cnt, cls_img, skip_img, spur_img, beats_total;
  logic [2:0][3:0] pred_tab;
  logic [3:0]      prev_addr;
  logic [3:0]      exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of environment: pixel scoreboard plus classifier model, all at the falling edge.
  task automatic cycle();
    logic [3:0] e;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.valid_out) begin
      beats_total++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix_addr", 32'(prev_addr), 32'(e));
        check("data_out", 32'(bus.data_out), 32'(pix_rom[e]));
      end
      beat++;
    end
    prev_addr = bus.pix_addr;
    bus.res_valid = 1'b0;
    if (bus.valid_out && beat == P) begin
      beat = 0;
      cnt  = LAT;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        if (cls_img != skip_img && cls_img < NI) begin
          bus.res_valid = 1'b1;
          bus.res_pred  = pred_tab[cls_img];
        end
        cls_img++;
      end
    end
    if (bus.valid_out && beat == 2 && cls_img == spur_img) bus.res_valid = 1'b1;
  endtask

  task automatic start_batch();
    cycle();
    bus.start   = 1'b1;
    beat        = 0;
    cnt         = 0;
    cls_img     = 0;
    beats_total = 0;
    exp_q.delete();
    for (int i = 0; i < NI * P; i++) exp_q.push_back(4'(i));
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (bus.done !== 1'b1 && n < budget);
    check("done_reached", 32'(bus.done), 32'd1);
  endtask

  task automatic check_final(input string tag, input int hit, input logic err);
    check({tag, "_img"},     32'(bus.img_count), NI);
    check({tag, "_hit"},     32'(bus.hit_count), 32'(hit));
    check({tag, "_err"},     32'(bus.err_spur), 32'(err));
    check({tag, "_busy"},    32'(bus.busy), 32'd0);
    check({tag, "_beats"},   32'(beats_total), NI * P);
`ifndef BATCH_TIMEOUT_EN
    check({tag, "_timeout"}, 32'(bus.timeout_cnt), 32'd0);
`endif
  endtask

  initial begin
    logic [15:0] pat;
    int          reached;
    pat = 16'b0110_1001_1100_1011;
    for (int i = 0; i < 16; i++) pix_rom[i] = pat[i];
    label_rom[0] = 4'd1;
    label_rom[1] = 4'd2;
    label_rom[2] = 4'd3;
    label_rom[3] = 4'd0;

    vec[0] = '{pred: {4'd3, 4'd2, 4'd1}, spur_img: -1, exp_hit: 3, exp_err: 1'b0};
    vec[1] = '{pred: {4'd3, 4'd0, 4'd1}, spur_img: -1, exp_hit: 2, exp_err: 1'b0};
    vec[2] = '{pred: {4'd3, 4'd2, 4'd1}, spur_img:  1, exp_hit: 3, exp_err: 1'b1};
    vec[3] = '{pred: {4'd0, 4'd0, 4'd0}, spur_img: -1, exp_hit: 0, exp_err: 1'b0};
    vec[4] = '{pred: {4'd1, 4'd2, 4'd3}, spur_img:  0, exp_hit: 1, exp_err: 1'b1};

    bus.start = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_pred = '0;
    skip_img = -1;
    spur_img = -1;
    pred_tab = '0;
    beat = 0; cnt = 0; cls_img = 0; beats_total = 0;
    prev_addr = '0;

    repeat (3) @(negedge clk);
    check("rst_busy",      32'(bus.busy), 32'd0);
    check("rst_done",      32'(bus.done), 32'd0);
    check("rst_valid",     32'(bus.valid_out), 32'd0);
    check("rst_pix_addr",  32'(bus.pix_addr), 32'd0);
    check("rst_img_count", 32'(bus.img_count), 32'd0);
    check("rst_err_spur",  32'(bus.err_spur), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      pred_tab = vec[v].pred;
      spur_img = vec[v].spur_img;
      start_batch();
      wait_done(300);
      check_final($sformatf("vec%0d", v), vec[v].exp_hit, vec[v].exp_err);
    end

    // Spurious result strobe while DONE: sticky error, score untouched
    spur_img = -1;
    cycle();
    bus.res_valid = 1'b1;
    cycle();
    cycle();
    check("done_spur_err",  32'(bus.err_spur), 32'd1);
    check("done_spur_hit",  32'(bus.hit_count), 32'd1);
    check("done_spur_done", 32'(bus.done), 32'd1);

    // start while busy is ignored; start in DONE clears the counters
    pred_tab = {4'd3, 4'd2, 4'd1};
    start_batch();
    repeat (20) cycle();
    bus.start = 1'b1;
    wait_done(300);
    check_final("busy_start", 3, 1'b0);
    start_batch();
    cycle();
    check("restart_img",  32'(bus.img_count), 32'd0);
    check("restart_hit",  32'(bus.hit_count), 32'd0);
    check("restart_busy", 32'(bus.busy), 32'd1);
    check("restart_done", 32'(bus.done), 32'd0);
    wait_done(300);
    check_final("restart", 3, 1'b0);

    // Reset during the WAIT of image 1 aborts; next batch restarts at address 0
    start_batch();
    reached = 0;
    for (int n = 0; n < 200 && reached == 0; n++) begin
      cycle();
      if (cls_img == 1 && cnt == 3) reached = 1;
    end
    check("reach_wait1", 32'(reached), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy",       32'(bus.busy), 32'd0);
    check("abort_valid",      32'(bus.valid_out), 32'd0);
    check("abort_pix_addr",   32'(bus.pix_addr), 32'd0);
    check("abort_label_addr", 32'(bus.label_addr), 32'd0);
    check("abort_img",        32'(bus.img_count), 32'd0);
    check("abort_data_out",   32'(bus.data_out), 32'd0);
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    check("rst_beats_start", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;
    start_batch();
    wait_done(300);
    check_final("after_abort", 3, 1'b0);

`ifdef BATCH_TIMEOUT_EN
    // Image 1 never answered: scored as a miss after the WAIT budget
    skip_img = 1;
    start_batch();
    wait_done(400);
    check("to_cnt",  32'(bus.timeout_cnt), 32'd1);
    check("to_hit",  32'(bus.hit_count), 32'd2);
    check("to_img",  32'(bus.img_count), NI);
    check("to_err",  32'(bus.err_spur), 32'd0);
    skip_img = -1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
